instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and types
// for the instruction fetch unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO buffering {pc,instr}
// pairs between the memory port and the decoder.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q < CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: nothing reads it while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with credit-limited
// requests, redirect drain and a small instruction buffer.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [ILEN-1:0] IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic [ILEN-1:0] INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            granted, resp_ok, push, pop;
  fetch_entry_t    push_entry, head;
  logic [EW-1:0]   fifo_rdata;

  assign INSTR_VALID = (fifo_count != '0);
  assign head        = fetch_entry_t'(fifo_rdata);

  always_comb begin
    occupancy = {1'b0, fifo_count} + {1'b0, outst_q};
    IMEM_REQ  = (state_q == FETCH) &&
                (occupancy < (CW+1)'(FIFO_DEPTH));
    IMEM_ADDR = fetch_pc_q;
    granted   = IMEM_REQ && IMEM_GNT;
    resp_ok   = IMEM_RVALID && (outst_q != '0);
    push      = resp_ok && (state_q == FETCH) && !REDIRECT;
    pop       = INSTR_VALID && INSTR_READY;
    // responses in FETCH are contiguous, so the oldest
    // outstanding address is fetch_pc minus the in-flight words
    push_entry.pc    = fetch_pc_q - XLEN'({outst_q, 2'b00});
    push_entry.instr = IMEM_RDATA;

    unique case ({granted, resp_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    fetch_pc_d = fetch_pc_q;
    if (REDIRECT) begin
      fetch_pc_d = {REDIRECT_PC[XLEN-1:2], 2'b00};
    end else if (granted) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (REDIRECT && outst_d != '0) state_d = DRAIN;
      DRAIN: if (outst_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .flush (REDIRECT),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign INSTR    = INSTR_VALID ? head.instr : RV_NOP;
  assign INSTR_PC = INSTR_VALID ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and directed stimulus against a
// program-order reference of the fetch stream.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IMEM_REQ, IMEM_GNT, IMEM_RVALID;
  logic [31:0] IMEM_ADDR, IMEM_RDATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC, INSTR, INSTR_PC;
  logic        INSTR_VALID, INSTR_READY;

  logic        W_REQ, W_GNT, W_RVALID, W_REDIRECT;
  logic [31:0] W_ADDR, W_RDATA, W_REDIRECT_PC;
  logic [31:0] W_INSTR, W_INSTR_PC;
  logic        W_VALID, W_READY;

  always #5 CLK = ~CLK;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY)
  );

  instr_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) u_wrap (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(W_REQ), .IMEM_ADDR(W_ADDR),
    .IMEM_GNT(W_GNT), .IMEM_RVALID(W_RVALID),
    .IMEM_RDATA(W_RDATA),
    .REDIRECT(W_REDIRECT), .REDIRECT_PC(W_REDIRECT_PC),
    .INSTR(W_INSTR), .INSTR_PC(W_INSTR_PC),
    .INSTR_VALID(W_VALID), .INSTR_READY(W_READY)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  pend_t       w_pend[$];
  logic [31:0] w_addrs[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_due = 0;
  int lat_min, lat_max, gnt_pct, rdy_pct, redir_pm;
  int gnt_total = 0;
  int consumed = 0;
  bit rst_drive, rst_prev;
  bit redir_req;
  logic [31:0] redir_target;
  logic [31:0] exp_pc, exp_fetch, w_exp_pc;
  bit exp_invalid;
  bit prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  bit last_gnt, last_hs;
  logic [31:0] last_gnt_addr, last_hs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    int d;
    @(negedge CLK);
    cyc++;
    RST = rst_drive;
    IMEM_GNT = IMEM_REQ && (int'($urandom_range(99)) < gnt_pct);
    INSTR_READY = int'($urandom_range(99)) < rdy_pct;
    REDIRECT = !rst_drive &&
               (redir_req || int'($urandom_range(999)) < redir_pm);
    REDIRECT_PC = redir_req ? redir_target : $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA = $urandom;
    end
    if (w_pend.size() > 0 && w_pend[0].due <= cyc) begin
      W_RVALID = 1'b1;
      W_RDATA = mem_word(w_pend[0].addr);
      void'(w_pend.pop_front());
    end else begin
      W_RVALID = 1'b0;
      W_RDATA = $urandom;
    end

    if (rst_prev) begin
      chk("rst_req", 32'(IMEM_REQ), 0);
      chk("rst_valid", 32'(INSTR_VALID), 0);
      chk("rst_instr", INSTR, RV_NOP);
      chk("rst_ipc", INSTR_PC, 0);
      chk("rst_addr", IMEM_ADDR, 0);
      chk("rst_waddr", W_ADDR, WRAP_PC);
    end
    if (exp_invalid) chk("flush_valid", 32'(INSTR_VALID), 0);
    if (prev_req && !prev_gnt && !prev_redir && !rst_prev) begin
      chk("req_hold", 32'(IMEM_REQ), 1);
      chk("addr_hold", IMEM_ADDR, prev_addr);
    end

    last_hs = 1'b0;
    if (INSTR_VALID && INSTR_READY) begin
      chk("instr_pc", INSTR_PC, exp_pc);
      chk("instr", INSTR, mem_word(exp_pc));
      last_hs = 1'b1;
      last_hs_pc = INSTR_PC;
      exp_pc += 4;
      consumed++;
    end

    last_gnt = 1'b0;
    if (IMEM_REQ && IMEM_GNT && !RST) begin
      chk("gnt_addr", IMEM_ADDR, exp_fetch);
      last_gnt = 1'b1;
      last_gnt_addr = IMEM_ADDR;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: IMEM_ADDR, due: d});
      exp_fetch += 4;
      gnt_total++;
    end

    exp_invalid = 1'b0;
    if (REDIRECT) begin
      exp_pc = {REDIRECT_PC[31:2], 2'b00};
      exp_fetch = exp_pc;
      exp_invalid = 1'b1;
    end
    if (RST) begin
      exp_pc = 32'h0;
      exp_fetch = 32'h0;
      w_exp_pc = WRAP_PC;
      w_addrs.delete();
    end else begin
      if (W_REQ) begin
        w_addrs.push_back(W_ADDR);
        w_pend.push_back('{addr: W_ADDR, due: cyc + 1});
      end
      if (W_VALID) begin
        chk("wrap_pc", W_INSTR_PC, w_exp_pc);
        chk("wrap_instr", W_INSTR, mem_word(w_exp_pc));
        w_exp_pc += 4;
      end
    end

    prev_req = IMEM_REQ;
    prev_gnt = IMEM_GNT;
    prev_redir = REDIRECT;
    prev_addr = IMEM_ADDR;
    rst_prev = RST;
    redir_req = 1'b0;
  endtask

  task automatic do_reset();
    lat_min = 1; lat_max = 1;
    gnt_pct = 100; rdy_pct = 100; redir_pm = 0;
    pend.delete();
    w_pend.delete();
    rst_drive = 1'b1;
    step();
    step();
    rst_drive = 1'b0;
    step();
  endtask

  task automatic wait_pending(input int n);
    for (int i = 0; i < 50; i++) begin
      if (pend.size() >= n) break;
      step();
    end
    chk("pend_wait", 32'(pend.size()), 32'(n));
  endtask

  task automatic wait_grant(output logic [31:0] a);
    a = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_gnt) begin
        a = last_gnt_addr;
        break;
      end
    end
  endtask

  task automatic wait_hs(output logic [31:0] pc);
    pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_hs) begin
        pc = last_hs_pc;
        break;
      end
    end
  endtask

  initial begin
    int first_valid, g0, c0;
    logic [31:0] a;
    IMEM_GNT = 0; IMEM_RVALID = 0; IMEM_RDATA = 0;
    REDIRECT = 0; REDIRECT_PC = 0; INSTR_READY = 0;
    W_GNT = 1'b1; W_RVALID = 0; W_RDATA = 0;
    W_REDIRECT = 1'b0; W_REDIRECT_PC = 0; W_READY = 1'b1;
    rst_prev = 0; redir_req = 0; redir_target = 0;
    exp_pc = 0; exp_fetch = 0; w_exp_pc = WRAP_PC;
    exp_invalid = 0; prev_req = 0; prev_gnt = 0;
    prev_redir = 0; prev_addr = 0;

    // basic streaming, first-valid latency, wrap instance
    do_reset();
    first_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (INSTR_VALID && first_valid == 0) first_valid = k;
    end
    chk("first_valid_lat", 32'(first_valid), 3);
    repeat (20) step();
    if (w_addrs.size() >= 3) begin
      chk("wrap_a0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_a1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_a2", w_addrs[2], 32'h0000_0000);
    end else begin
      chk("wrap_cnt", 32'(w_addrs.size()), 3);
    end

    // decoder stall
    do_reset();
    rdy_pct = 0;
    g0 = gnt_total;
    repeat (13) step();
    chk("stall_grants", 32'(gnt_total - g0), DEPTH);
    chk("stall_req", 32'(IMEM_REQ), 0);
    rdy_pct = 100;
    c0 = consumed;
    repeat (20) step();
    chk("resume_flow", 32'(consumed - c0 >= 10), 1);

    // redirect with two outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    wait_pending(2);
    redir_req = 1'b1; redir_target = 32'h100;
    step();
    step();
    chk("drain_req", 32'(IMEM_REQ), 0);
    wait_grant(a);
    chk("redir_addr", a, 32'h100);
    wait_hs(a);
    chk("redir_first_pc", a, 32'h100);

    // unaligned target, then redirect while draining
    do_reset();
    lat_min = 3; lat_max = 3;
    wait_pending(2);
    redir_req = 1'b1; redir_target = 32'h203;
    step();
    wait_grant(a);
    chk("align_addr", a, 32'h200);
    wait_pending(2);
    redir_req = 1'b1; redir_target = 32'h300;
    step();
    redir_req = 1'b1; redir_target = 32'h400;
    step();
    wait_grant(a);
    chk("drain_redir_addr", a, 32'h400);
    wait_hs(a);
    chk("drain_redir_pc", a, 32'h400);

    // reset with requests in flight
    do_reset();
    lat_min = 3; lat_max = 3; rdy_pct = 0;
    wait_pending(2);
    rst_drive = 1'b1;
    step();
    rst_drive = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_valid", 32'(INSTR_VALID), 0);
    end
    rdy_pct = 100;
    c0 = consumed;
    repeat (20) step();
    chk("post_rst_flow", 32'(consumed - c0 >= 3), 1);

    // random traffic with random redirects
    do_reset();
    lat_min = 1; lat_max = 4;
    gnt_pct = 70; rdy_pct = 60; redir_pm = 30;
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
